// File: rtl/mem_responder.sv
// mem_responder: multi-cycle 16-bit word memory answering single reads,
// single writes and wrapping burst reads. Read beats appear a fixed number
// of cycles after acceptance. All outputs come straight from flops.
module mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned MEM_AW    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic        burst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        ready,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        data_last
);

  localparam int unsigned BL_W  = $clog2(BURST_LEN);
  localparam int unsigned CNT_W = 4;
  // WAIT lasts LATENCY-1 cycles, so the counter starts at LATENCY-2.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (LATENCY > 1) ? CNT_W'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Storage is deliberately not reset; contents survive rst.
  logic [15:0] mem_q [0:(1 << MEM_AW) - 1];

  state_e            state_q;
  logic [MEM_AW-1:0] base_q;
  logic              burst_q;
  logic [BL_W-1:0]   beat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic [15:0]       data_out_q;
  logic              data_valid_q;
  logic              data_last_q;

  logic [MEM_AW-1:0] req_word_s;
  logic [MEM_AW-1:0] base_s;
  logic [BL_W-1:0]   beat_s;
  logic              burst_s;
  logic [MEM_AW-1:0] beat_word_s;
  logic [15:0]       beat_data_s;
  logic              beat_last_s;
  logic              unused_addr_s;

  assign req_word_s    = addr[MEM_AW:1];
  assign unused_addr_s = ^{addr[15:MEM_AW+1], addr[0]};

  assign ready      = ready_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;

  // Address, data and last flag of the beat that would be emitted at the next edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      base_s  = req_word_s;
      burst_s = burst;
    end else begin
      base_s  = base_q;
      burst_s = burst_q;
    end
    if (state_q == ST_RESP) begin
      beat_s = beat_q;
    end else begin
      beat_s = '0;
    end
    // Critical word first, wrapping inside the aligned burst block.
    beat_word_s             = base_s;
    beat_word_s[BL_W-1:0]   = base_s[BL_W-1:0] + beat_s;
    beat_data_s             = mem_q[beat_word_s];
    beat_last_s             = (!burst_s) || (beat_s == BL_W'(BURST_LEN - 1));
  end

  // Commit writes only when idle and not in reset; busy-time enables are dropped.
  always_ff @(posedge clk) begin
    if (!rst && ready_q && enable && wr) begin
      mem_q[req_word_s] <= data_in;
    end
  end

  // Request FSM: accept, count out the latency, then stream the read beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      burst_q      <= 1'b0;
      beat_q       <= '0;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b1;
      data_out_q   <= 16'h0000;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && !wr) begin
            base_q  <= req_word_s;
            burst_q <= burst;
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= ST_RESP;
              data_valid_q <= 1'b1;
              data_out_q   <= beat_data_s;
              data_last_q  <= beat_last_s;
              beat_q       <= beat_s + 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            data_valid_q <= 1'b1;
            data_out_q   <= beat_data_s;
            data_last_q  <= beat_last_s;
            beat_q       <= beat_s + 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (data_last_q) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            beat_q       <= '0;
            data_valid_q <= 1'b0;
            data_out_q   <= 16'h0000;
            data_last_q  <= 1'b0;
          end else begin
            data_valid_q <= 1'b1;
            data_out_q   <= beat_data_s;
            data_last_q  <= beat_last_s;
            beat_q       <= beat_s + 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          beat_q       <= '0;
          cnt_q        <= 4'd0;
          data_valid_q <= 1'b0;
          data_out_q   <= 16'h0000;
          data_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected beats with
// their expected cycle; a negedge monitor pops and compares each beat.
module tb_mem_responder;

  localparam int L = 4;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic        burst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic        ready;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_last;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          at;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    bw[8] = '{3, 4, 5, 6, 7, 0, 1, 2};

  mem_responder #(.LATENCY(L), .BURST_LEN(B), .MEM_AW(12)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .burst(burst),
    .addr(addr), .data_in(data_in), .ready(ready), .data_out(data_out),
    .data_valid(data_valid), .data_last(data_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (cycle %0d)", data_out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", int'(data_out), int'(mon_e.data));
          check("beat_last", int'(data_last), int'(mon_e.last));
          check("beat_cycle", cyc, mon_e.at);
        end
      end else begin
        check("idle_data_out", int'(data_out), 0);
        check("idle_data_last", int'(data_last), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic b);
    enable = 1'b1; wr = 1'b1; burst = b; addr = a; data_in = d;
    tick();
    enable = 1'b0; wr = 1'b0; burst = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic b, output int e0);
    enable = 1'b1; wr = 1'b0; burst = b; addr = a;
    tick();
    e0 = cyc;
    enable = 1'b0; burst = 1'b0;
  endtask

  task automatic expect_beat(input logic [15:0] d, input logic last, input int at);
    beat_t e;
    e.data = d; e.last = last; e.at = at;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for ready to return and check the cycle it does.
  task automatic wait_idle(input string name, input int e0, input int nb);
    bit seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      check(name, cyc, e0 + L + nb - 1);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: ready never returned, expected at cycle %0d", name, e0 + L + nb - 1);
    end
  endtask

  task automatic rd1(input logic [15:0] a, input logic [15:0] d, input string name);
    int e0;
    do_read(a, 1'b0, e0);
    expect_beat(d, 1'b1, e0 + L - 1);
    wait_idle(name, e0, 1);
  endtask

  initial begin
    int e0;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_ready", int'(ready), 1);
    check("reset_valid", int'(data_valid), 0);
    check("reset_data_out", int'(data_out), 0);

    // rst overrides a same-cycle write
    do_write(16'h0100, 16'h1111, 1'b0);
    rst = 1'b1; enable = 1'b1; wr = 1'b1; addr = 16'h0100; data_in = 16'hDEAD;
    tick();
    tick();
    rst = 1'b0; enable = 1'b0; wr = 1'b0;
    check("rst_write_ready", int'(ready), 1);
    check("rst_write_valid", int'(data_valid), 0);
    check("rst_write_data_out", int'(data_out), 0);
    rd1(16'h0100, 16'h1111, "blocked_write_ready");

    // write then read next cycle, odd byte address, aliased address
    do_write(16'h0010, 16'hBEEF, 1'b0);
    rd1(16'h0010, 16'hBEEF, "single_read_ready");
    rd1(16'h0011, 16'hBEEF, "odd_addr_ready");
    rd1(16'h2010, 16'hBEEF, "alias_ready");

    // wrapping burst, critical word first
    for (int i = 0; i < 8; i++) do_write(16'(2 * i), 16'(16'h1000 + i), 1'b0);
    do_read(16'h0006, 1'b1, e0);
    for (int k = 0; k < B; k++) expect_beat(16'(16'h1000 + bw[k]), (k == B - 1), e0 + L - 1 + k);
    wait_idle("burst_ready", e0, B);

    // write pulse while busy is dropped
    do_write(16'h0020, 16'h7777, 1'b0);
    do_read(16'h0010, 1'b0, e0);
    expect_beat(16'hBEEF, 1'b1, e0 + L - 1);
    check("busy_ready", int'(ready), 0);
    do_write(16'h0020, 16'h1234, 1'b0);
    wait_idle("busy_read_ready", e0, 1);
    rd1(16'h0020, 16'h7777, "ignored_write_ready");

    // reset on the third burst beat abandons the rest
    do_read(16'h0006, 1'b1, e0);
    for (int k = 0; k < 3; k++) expect_beat(16'(16'h1000 + bw[k]), 1'b0, e0 + L - 1 + k);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", int'(data_valid), 0);
    check("abort_ready", int'(ready), 1);
    repeat (12) tick();
    check("abort_pending", exp_q.size(), 0);
    rd1(16'h0010, 16'hBEEF, "after_abort_ready");

    // write with burst=1 is a plain single write
    do_write(16'h0042, 16'hC3C3, 1'b0);
    do_write(16'h0040, 16'h5A5A, 1'b1);
    check("burst_write_ready", int'(ready), 1);
    check("burst_write_valid", int'(data_valid), 0);
    rd1(16'h0040, 16'h5A5A, "burst_write_rd_ready");
    rd1(16'h0042, 16'hC3C3, "neighbour_ready");

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle word memory acting as the responder end of the processor's memory request interface. It accepts single read, single write and burst read requests from an initiator (the pipeline's memory stage or a cache fill engine), stalls new requests while busy, and returns read data after a fixed latency with a per-beat valid strobe. It replaces the single-cycle memory model once the pipelined design needs realistic memory timing.

## Interface
- LATENCY, 4, cycles from request acceptance to first read beat; legal range 1..15
- BURST_LEN, 8, beats per burst read; power of two, 2..16
- MEM_AW, 12, log2 of storage depth in 16-bit words
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  request strobe; accepted only when ready=1
- wr  in  1  1 = write, 0 = read; sampled with enable
- burst  in  1  1 = burst read; ignored when wr=1
- addr  in  16  byte address; bit 0 ignored; word index = addr[MEM_AW:1]; higher bits ignored (aliasing)
- data_in  in  16  write data; sampled with enable
- ready  out  1  1 when a request can be accepted
- data_out  out  16  read beat data; 0 whenever data_valid=0
- data_valid  out  1  one cycle per read beat
- data_last  out  1  high with the final beat of a request (every single read; 8th beat of a default burst)

## Operation
- States: IDLE, WAIT, RESP. ready = (state == IDLE).
- IDLE, enable=1, wr=1: array[word] <= data_in at that edge; state stays IDLE; no data_valid. burst ignored.
- IDLE, enable=1, wr=0: latch word address, burst flag; load wait counter; go WAIT (LATENCY>1) or RESP (LATENCY=1).
- WAIT: count down LATENCY-1 cycles, then RESP.
- RESP: each cycle drive data_valid=1, data_out=array[beat address]. Single read: one beat, data_last=1, then IDLE. Burst: BURST_LEN consecutive beats, then IDLE.
- Burst addressing: critical word first, wrapping within the aligned BURST_LEN-word block; beat k word index = {base[MEM_AW-1:log2 BURST_LEN], (base_low + k) mod BURST_LEN}.
- Read data sampled from the array at the beat cycle; no write can intervene while busy.
- enable while ready=0: ignored entirely (no write, no queueing); initiator must hold or re-issue.
- Array contents undefined at power-up, not cleared by rst.

## Timing
- Reset: state=IDLE, ready=1, data_valid=0, data_last=0, data_out=0, counters=0; takes effect at the edge where rst=1. rst overrides a same-cycle enable (write not committed).
- Reset mid-WAIT or mid-burst: remaining beats abandoned; outputs return to reset values after that edge; array preserved.
- Request accepted at edge E0 (enable=1, ready=1). First read beat visible in the cycle following edge E0+LATENCY-1, i.e. LATENCY cycles after the accepting cycle.
- ready low from cycle after E0 through the last beat cycle; high the cycle after the last beat. Back-to-back single reads: one accept every LATENCY+1 cycles; bursts every LATENCY+BURST_LEN cycles.
- Writes: zero busy cycles; writes every cycle are legal; a read accepted the cycle after a write to the same word returns the new data.
- data_valid never asserted in IDLE or WAIT; data_last only with data_valid.

## Test plan
- Reset: assert rst 2 cycles with enable=1, wr=1 -> ready=1, data_valid=0, data_out=0; later read of that address does not return the blocked data.
- Write 0xBEEF to 0x0010, read 0x0010 next cycle -> data_valid=1, data_out=0xBEEF, data_last=1 exactly 4 cycles after the read-accept cycle; ready=0 for those 4 cycles; read 0x0011 also returns 0xBEEF.
- Fill words 0x0000..0x000E with 0x1000+index, burst read at 0x0006 -> 8 consecutive beats from addresses 0x6,0x8,0xA,0xC,0xE,0x0,0x2,0x4; data_last only on 8th; ready high next cycle.
- Pulse enable with wr=1, data 0x1234 at 0x0020 while in WAIT -> ignored; subsequent read of 0x0020 returns prior contents.
- Assert rst on 3rd beat of a burst -> data_valid=0 next cycle, no further beats, ready=1; new read completes normally.
- wr=1 with burst=1 at 0x0040 value 0x5A5A -> single write, ready stays 1, no data_valid; 0x0042 unchanged.
